twofish_round_engine: RTL and testbench
=======================================

# twofish_round_engine

Iterative, parametrised Twofish round engine. Holds one 128-bit block (four 32-bit words R0..R3) and runs NUM_ROUNDS Feistel rounds in either encrypt or decrypt mode. It requests F-function results for each round from an external F unit over a request/acknowledge handshake. It returns the un-swapped result on a valid/ready output port and sits between whitening and the F/key-schedule logic in the cipher datapath.

## Interface
- NUM_ROUNDS, 16, rounds per block; legal range 1..16.
- ROUND_W, max(1, $clog2(NUM_ROUNDS)), width of the round index.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block offered.
- in_ready  out  1  engine can accept a block.
- in_block  in  128  R0=[31:0], R1=[63:32], R2=[95:64], R3=[127:96].
- in_decrypt  in  1  mode for this block, sampled on accept; 1 = decrypt.
- f_req  out  1  F evaluation requested for the current round.
- f_r0, f_r1  out  32 each  current R0 and R1 operands to the F unit.
- f_round  out  ROUND_W  subkey round index.
- f_ack  in  1  F0/F1 valid this cycle.
- f_f0, f_f1  in  32 each  F-function outputs.
- out_valid  out  1  result block available.
- out_ready  in  1  consumer accepts the result.
- out_block  out  128  result, same word packing as in_block.
- out_decrypt  out  1  mode the result was produced in.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid, load R0..R3, latch the mode, clear round count r, and go to ROUND.
- ROUND: f_req=1, f_r0=R0, f_r1=R1. f_round=r in encrypt mode and NUM_ROUNDS-1-r in decrypt mode. On a cycle with f_req && f_ack the engine registers the round mix and increments r. If r was NUM_ROUNDS-1, it goes to DONE; otherwise it stays in ROUND.
- Encrypt mix: nR0 = ror1(f_f0 ^ R2); nR1 = rol1(R3) ^ f_f1; nR2 = R0; nR3 = R1.
- Decrypt mix: nR0 = rol1(R2) ^ f_f0; nR1 = ror1(R3 ^ f_f1); nR2 = R0; nR3 = R1.
- rol1 and ror1 are 32-bit rotates by one. Each rotate wraps the MSB into the LSB or the LSB into the MSB. No widening.
- DONE: out_valid=1. out_block words are {R1,R0,R3,R2} from MSB to LSB, which undoes the last swap (out word0=R2, word1=R3, word2=R0, word3=R1). On out_ready the engine returns to IDLE.
- Because the output swap matches the input word order, feeding an encrypt result back in decrypt mode with the same F/subkeys returns the original block.
- f_ack outside ROUND is ignored. in_valid outside IDLE is ignored, since in_ready=0.
- Reset, asynchronous at any time including mid-round: state IDLE; R0..R3=0; r=0; mode=0. The engine drops f_req immediately and discards any partial block.

## Timing
- Reset values: in_ready=1, f_req=0, f_r0=f_r1=0, f_round=0, out_valid=0, out_block=0, out_decrypt=0, busy=0.
- Accept at edge k: f_req is high from cycle k+1.
- f_ack may be combinational in the same cycle as f_req. Each round then takes one cycle.
- f_ack held low for n cycles stretches that round by n cycles. f_req and the operands stay stable throughout.
- Minimum latency from accept to out_valid is NUM_ROUNDS+1 cycles.
- out_valid and out_block hold stable until out_ready. With out_ready already high, DONE lasts one cycle.
- in_ready rises the cycle after the output handshake. There is no overlap between blocks.

## Structure
- twofish_pkg holds WORD_W=32, BLOCK_W=128, the FSM state enum, and the rol1/ror1 functions.
- Sub-module twofish_round_mix: combinational mode-selected mix. Inputs are R0..R3, f0, f1 and decrypt; outputs are nR0..nR3.
- twofish_round_engine holds the FSM, the round counter and the state registers.

## Test plan
- NUM_ROUNDS=1, encrypt, F0=F1=0, in words R0..R3 = 1, 2, 3, 0x80000000 → out words = 1, 2, 0x80000001, 0x00000001.
- Feed that output back in decrypt mode with F0=F1=0 → out words = 1, 2, 3, 0x80000000.
- NUM_ROUNDS=16 round trip with a bench F model (f0 = f_r0 ^ K[f_round], f1 = f_r1 + K[f_round]) and random blocks → decrypt(encrypt(x)) == x. Decrypt must present f_round sequence 15..0; encrypt must present 0..15.
- f_ack delayed 3 cycles on round 5 and out_ready held low 4 cycles → total latency 16+1+3 cycles. Operands and out_block stay stable, and in_valid is ignored while busy.
- Assert rst_n low during round 7 → f_req drops immediately, all outputs take their reset values, and the next block processes correctly from round 0.

Source files
------------

// File: rtl/twofish_pkg.sv
// Shared types, widths and word rotations for the Twofish round engine.
package twofish_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Rotate left by one: MSB wraps into the LSB.
  function automatic word_t rol1(input word_t x);
    return {x[WORD_W-2:0], x[WORD_W-1]};
  endfunction

  // Rotate right by one: LSB wraps into the MSB.
  function automatic word_t ror1(input word_t x);
    return {x[0], x[WORD_W-1:1]};
  endfunction

endpackage

// File: rtl/twofish_round_mix.sv
// Combinational Feistel mix for one Twofish round, encrypt or decrypt.
module twofish_round_mix
  import twofish_pkg::*;
(
  input  word_t r0,
  input  word_t r1,
  input  word_t r2,
  input  word_t r3,
  input  word_t f0,
  input  word_t f1,
  input  logic  decrypt,
  output word_t n0,
  output word_t n1,
  output word_t n2,
  output word_t n3
);

  // Mode-selected mix; the F operands move into the upper half every round.
  always_comb begin
    if (decrypt) begin
      n0 = rol1(r2) ^ f0;
      n1 = ror1(r3 ^ f1);
    end else begin
      n0 = ror1(f0 ^ r2);
      n1 = rol1(r3) ^ f1;
    end
    n2 = r0;
    n3 = r1;
  end

endmodule

// File: rtl/twofish_round_engine.sv
// Iterative Twofish round engine: one block in flight, one round per F handshake.
module twofish_round_engine
  import twofish_pkg::*;
#(
  parameter int NUM_ROUNDS = 16,
  parameter int ROUND_W    = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic               in_decrypt,
  output logic               f_req,
  output logic [WORD_W-1:0]  f_r0,
  output logic [WORD_W-1:0]  f_r1,
  output logic [ROUND_W-1:0] f_round,
  input  logic               f_ack,
  input  logic [WORD_W-1:0]  f_f0,
  input  logic [WORD_W-1:0]  f_f1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               out_decrypt,
  output logic               busy
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  state_t             state, state_next;
  word_t              r0, r1, r2, r3;
  word_t              n0, n1, n2, n3;
  logic [ROUND_W-1:0] round_q;
  logic               decrypt_q;
  logic               load, step;

  twofish_round_mix u_mix (
    .r0      (r0),
    .r1      (r1),
    .r2      (r2),
    .r3      (r3),
    .f0      (f_f0),
    .f1      (f_f1),
    .decrypt (decrypt_q),
    .n0      (n0),
    .n1      (n1),
    .n2      (n2),
    .n3      (n3)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake decode.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    f_req      = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = ST_ROUND;
        end
      end
      ST_ROUND: begin
        f_req = 1'b1;
        if (f_ack) begin
          step = 1'b1;
          if (round_q == LAST_ROUND) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Block words, round counter and mode: load on accept, advance on each F handshake.
  // NOTE: these are plain flops, so all of them reset; a reset mid-block discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0        <= '0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      round_q   <= '0;
      decrypt_q <= 1'b0;
    end else if (load) begin
      r0        <= in_block[31:0];
      r1        <= in_block[63:32];
      r2        <= in_block[95:64];
      r3        <= in_block[127:96];
      round_q   <= '0;
      decrypt_q <= in_decrypt;
    end else if (step) begin
      r0      <= n0;
      r1      <= n1;
      r2      <= n2;
      r3      <= n3;
      round_q <= round_q + ROUND_W'(1);
    end
  end

  // Decrypt walks the subkeys backwards; the output undoes the final swap.
  assign f_r0        = r0;
  assign f_r1        = r1;
  assign f_round     = decrypt_q ? (LAST_ROUND - round_q) : round_q;
  assign out_block   = {r1, r0, r3, r2};
  assign out_decrypt = decrypt_q;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_twofish_round_engine.sv
// Directed bench: a 1-round engine checked against hand-computed vectors and a
// 16-round engine checked for round trip, subkey order, stalls and mid-block reset.
module tb_twofish_round_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- 16-round engine with a keyed F model ----------------
  logic         in_valid, in_ready, in_decrypt, f_req, f_ack, out_valid, out_ready, out_decrypt, busy;
  logic [127:0] in_block, out_block;
  logic [31:0]  f_r0, f_r1, f_f0, f_f1;
  logic [3:0]   f_round;
  logic         ack_en;
  logic [31:0]  kt [16];

  assign f_f0  = f_r0 ^ kt[f_round];
  assign f_f1  = f_r1 + kt[f_round];
  assign f_ack = f_req && ack_en;

  twofish_round_engine #(.NUM_ROUNDS(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_decrypt(in_decrypt),
    .f_req(f_req), .f_r0(f_r0), .f_r1(f_r1), .f_round(f_round),
    .f_ack(f_ack), .f_f0(f_f0), .f_f1(f_f1),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_decrypt(out_decrypt), .busy(busy)
  );

  // ---------------- 1-round engine with F tied to zero ----------------
  logic         s_in_valid, s_in_ready, s_in_decrypt, s_f_req, s_f_ack, s_out_valid, s_out_ready;
  logic         s_out_decrypt, s_busy, s_ack_extra;
  logic [127:0] s_in_block, s_out_block;
  logic [31:0]  s_f_r0, s_f_r1;
  logic [0:0]   s_f_round;

  assign s_f_ack = s_f_req | s_ack_extra;

  twofish_round_engine #(.NUM_ROUNDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_block(s_in_block), .in_decrypt(s_in_decrypt),
    .f_req(s_f_req), .f_r0(s_f_r0), .f_r1(s_f_r1), .f_round(s_f_round),
    .f_ack(s_f_ack), .f_f0(32'h0), .f_f1(32'h0),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_block(s_out_block),
    .out_decrypt(s_out_decrypt), .busy(s_busy)
  );

  // Independent 16-round encrypt model, word packing {w3,w2,w1,w0}.
  function automatic logic [127:0] enc_model(input logic [127:0] b);
    logic [31:0] a0, a1, a2, a3, t, n0, n1, f0, f1;
    a0 = b[31:0]; a1 = b[63:32]; a2 = b[95:64]; a3 = b[127:96];
    for (int i = 0; i < 16; i++) begin
      f0 = a0 ^ kt[i];
      f1 = a1 + kt[i];
      t  = f0 ^ a2;
      n0 = {t[0], t[31:1]};
      n1 = {a3[30:0], a3[31]} ^ f1;
      a2 = a0; a3 = a1; a0 = n0; a1 = n1;
    end
    return {a1, a0, a3, a2};
  endfunction

  // One block through the 16-round engine with immediate acks; returns cycles
  // from accept to out_valid (-1 on timeout) and a count of subkey-order faults.
  task automatic run16(input logic [127:0] blk, input logic dec, output logic [127:0] res,
                       output logic rdec, output int lat, output int seq_bad);
    int idx;
    bit done;
    @(negedge clk);
    in_valid = 1'b1; in_block = blk; in_decrypt = dec;
    @(posedge clk);
    lat = 1; idx = 0; seq_bad = 0; done = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (out_valid) done = 1'b1;
      else begin
        if (f_req && f_ack) begin
          if (f_round !== 4'(dec ? 15 - idx : idx)) seq_bad++;
          idx++;
        end
        @(posedge clk); lat++;
        @(negedge clk);
      end
    end
    if (idx != 16) seq_bad++;
    if (!done) lat = -1;
    res  = out_block;
    rdec = out_decrypt;
    @(posedge clk);
  endtask

  // One block through the 1-round engine.
  task automatic run1(input logic [127:0] blk, input logic dec, output logic [127:0] res,
                      output logic rdec, output int lat);
    bit done;
    @(negedge clk);
    s_in_valid = 1'b1; s_in_block = blk; s_in_decrypt = dec;
    @(posedge clk);
    lat = 1; done = 1'b0;
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (s_out_valid) done = 1'b1;
      else begin
        @(posedge clk); lat++;
        @(negedge clk);
      end
    end
    if (!done) lat = -1;
    res  = s_out_block;
    rdec = s_out_decrypt;
    @(posedge clk);
  endtask

  typedef struct {
    logic [127:0] blk;
    logic         dec;
    logic [127:0] exp;
  } vec_t;

  vec_t         vt [5];
  logic [127:0] blks [4];

  initial begin
    logic [127:0] res, enc, cap, want;
    logic         rdec, found;
    int           lat, seq_bad, stalls, busy_bad, stab_bad, hold_bad, idle_bad;
    logic [31:0]  c_r0, c_r1;
    logic [3:0]   c_round;

    for (int i = 0; i < 16; i++) kt[i] = (32'h9E3779B9 * 32'(i + 1)) ^ (32'(i) << 24);
    rst_n = 1'b0;
    in_valid = 1'b0; in_block = '0; in_decrypt = 1'b0; out_ready = 1'b1; ack_en = 1'b1;
    s_in_valid = 1'b0; s_in_block = '0; s_in_decrypt = 1'b0; s_out_ready = 1'b1; s_ack_extra = 1'b0;

    // Reset values.
    #12;
    check("reset_ctrl", 128'({in_ready, f_req, out_valid, out_decrypt, busy}), 128'(5'b10000));
    check("reset_operands", 128'({f_r0, f_r1, f_round}), 128'h0);
    check("reset_out_block", out_block, 128'h0);
    check("reset_ctrl_1r", 128'({s_in_ready, s_f_req, s_out_valid, s_out_decrypt, s_busy}), 128'(5'b10000));
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed single-round vectors, F0 = F1 = 0.
    vt[0] = '{{32'h80000000, 32'h3, 32'h2, 32'h1}, 1'b0, {32'h1, 32'h80000001, 32'h2, 32'h1}};
    vt[1] = '{{32'h1, 32'h80000001, 32'h2, 32'h1}, 1'b1, {32'h80000000, 32'h3, 32'h2, 32'h1}};
    vt[2] = '{128'h0, 1'b0, 128'h0};
    vt[3] = '{{32'h1, 32'h1, 32'h0, 32'h0}, 1'b0, {32'h2, 32'h80000000, 32'h0, 32'h0}};
    vt[4] = '{{32'h1, 32'h2, 32'h0, 32'h0}, 1'b1, {32'h80000000, 32'h4, 32'h0, 32'h0}};
    for (int i = 0; i < 5; i++) begin
      run1(vt[i].blk, vt[i].dec, res, rdec, lat);
      check($sformatf("r1_block_%0d", i), res, vt[i].exp);
      check($sformatf("r1_mode_%0d", i), 128'(rdec), 128'(vt[i].dec));
      check($sformatf("r1_latency_%0d", i), 128'(lat), 128'(2));
    end

    // f_ack while idle is ignored.
    idle_bad = 0;
    @(negedge clk);
    s_ack_extra = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (s_busy || s_out_valid || !s_in_ready) idle_bad++;
    end
    s_ack_extra = 1'b0;
    check("idle_ack_ignored", 128'(idle_bad), 128'h0);

    // 16-round round trip, subkey order and minimum latency.
    blks[0] = {32'h80000000, 32'h3, 32'h2, 32'h1};
    blks[1] = 128'h0;
    blks[2] = {$urandom, $urandom, $urandom, $urandom};
    blks[3] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      run16(blks[i], 1'b0, enc, rdec, lat, seq_bad);
      check($sformatf("enc_block_%0d", i), enc, enc_model(blks[i]));
      check($sformatf("enc_order_%0d", i), 128'(seq_bad), 128'h0);
      check($sformatf("enc_latency_%0d", i), 128'(lat), 128'(17));
      run16(enc, 1'b1, res, rdec, lat, seq_bad);
      check($sformatf("dec_block_%0d", i), res, blks[i]);
      check($sformatf("dec_mode_%0d", i), 128'(rdec), 128'h1);
      check($sformatf("dec_order_%0d", i), 128'(seq_bad), 128'h0);
    end

    // Round 5 stalled 3 cycles, out_ready low 4 cycles, in_valid held while busy.
    want = enc_model(blks[2]);
    @(negedge clk);
    in_valid = 1'b1; in_block = blks[2]; in_decrypt = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    lat = 1; stalls = 0; busy_bad = 0; stab_bad = 0; found = 1'b0;
    c_r0 = '0; c_r1 = '0; c_round = '0;
    @(negedge clk);
    in_block = blks[3];
    for (int c = 0; c < 100 && !found; c++) begin
      if (out_valid) found = 1'b1;
      else begin
        if (f_req && f_round == 4'd5 && stalls < 3) begin
          ack_en = 1'b0;
          if (stalls == 0) begin c_r0 = f_r0; c_r1 = f_r1; c_round = f_round; end
          else if (f_r0 !== c_r0 || f_r1 !== c_r1 || f_round !== c_round) stab_bad++;
          stalls++;
        end else ack_en = 1'b1;
        if (in_ready) busy_bad++;
        @(posedge clk); lat++;
        @(negedge clk);
      end
    end
    ack_en = 1'b1;
    check("stall_latency", 128'(found ? lat : -1), 128'(20));
    check("stall_operands_stable", 128'(stab_bad), 128'h0);
    check("busy_blocks_input", 128'(busy_bad), 128'h0);
    cap = out_block;
    hold_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!out_valid || out_block !== cap || in_ready) hold_bad++;
    end
    check("out_hold_stable", 128'(hold_bad), 128'h0);
    check("stall_block", cap, want);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_out", 128'({in_ready, out_valid, busy}), 128'(3'b100));

    // Reset during round 7, then a clean block.
    @(negedge clk);
    in_valid = 1'b1; in_block = blks[3]; in_decrypt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (f_req && f_round == 4'd8) found = 1'b1; // decrypt: round 7 presents subkey 8
      else @(negedge clk);
    end
    check("reached_round_7", 128'(found), 128'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ctrl", 128'({in_ready, f_req, out_valid, out_decrypt, busy}), 128'(5'b10000));
    check("midreset_operands", 128'({f_r0, f_r1, f_round}), 128'h0);
    check("midreset_out_block", out_block, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run16(blks[3], 1'b0, res, rdec, lat, seq_bad);
    check("after_reset_block", res, enc_model(blks[3]));
    check("after_reset_order", 128'(seq_bad), 128'h0);
    check("after_reset_latency", 128'(lat), 128'(17));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
